// File: rtl/sobel_edge.sv
// Streaming 3x3 Sobel edge-magnitude stage: two line buffers, a 3x3 window and a
// three-stage pipe, with edge mode latched only at frame boundaries so no frame is torn.
module sobel_edge #(
  parameter int         H_ACTIVE = 640,
  parameter int         BINARY   = 0,
  parameter logic [7:0] THRESH   = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_en,
  input  logic        in_valid,
  input  logic [7:0]  in_R,
  input  logic [7:0]  in_G,
  input  logic [7:0]  in_B,
  output logic [7:0]  out_R,
  output logic [7:0]  out_G,
  output logic [7:0]  out_B,
  input  logic [23:0] pass_in,
  output logic [23:0] pass_thru
);

  localparam int            CW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [1:0]    row_q, row_d, row_cur;
  logic          en_frame_q;

  logic [7:0] lb0_mem [H_ACTIVE];
  logic [7:0] lb1_mem [H_ACTIVE];
  logic [7:0] lb0_rd, lb1_rd;

  // Stage 1: window plus the bypass/control copies travelling with it.
  logic [7:0]  win_q [3][3];
  logic        v1_q, border1_q;
  logic [23:0] rgb1_q, pass1_q;
  // Stage 2: masked pixel result.
  logic [7:0]  pix2_q;
  logic        v2_q;
  logic [23:0] rgb2_q, pass2_q;

  logic [9:0]  gx_pos, gx_neg, gy_pos, gy_neg, gx_abs, gy_abs;
  logic [11:0] mag;
  logic [7:0]  sat, pix;

  // A frame_en coinciding with a pixel makes that pixel col 0 / row 0 of the new frame.
  always_comb begin
    col_cur = frame_en ? '0 : col_q;
    row_cur = frame_en ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end else if (frame_en) begin
      col_d = '0;
      row_d = '0;
    end
  end

  assign lb0_rd = lb0_mem[col_cur];
  assign lb1_rd = lb1_mem[col_cur];

  // Line RAM is deliberately not reset; the border mask hides stale contents.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb0_mem[col_cur] <= in_G;
      lb1_mem[col_cur] <= lb0_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      en_frame_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (frame_en) en_frame_q <= enable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      v1_q      <= 1'b0;
      border1_q <= 1'b0;
      rgb1_q    <= '0;
      pass1_q   <= '0;
    end else begin
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_rd;
        win_q[1][2] <= lb0_rd;
        win_q[2][2] <= in_G;
      end
      v1_q      <= in_valid;
      border1_q <= (col_cur >= CW'(2)) && (row_cur == 2'd2);
      rgb1_q    <= {in_R, in_G, in_B};
      pass1_q   <= pass_in;
    end
  end

  // |Gx| and |Gy| as absolute differences of the two weighted 10-bit sums.
  always_comb begin
    gx_pos = {2'b0, win_q[0][2]} + {1'b0, win_q[1][2], 1'b0} + {2'b0, win_q[2][2]};
    gx_neg = {2'b0, win_q[0][0]} + {1'b0, win_q[1][0], 1'b0} + {2'b0, win_q[2][0]};
    gy_pos = {2'b0, win_q[2][0]} + {1'b0, win_q[2][1], 1'b0} + {2'b0, win_q[2][2]};
    gy_neg = {2'b0, win_q[0][0]} + {1'b0, win_q[0][1], 1'b0} + {2'b0, win_q[0][2]};
    gx_abs = (gx_pos >= gx_neg) ? gx_pos - gx_neg : gx_neg - gx_pos;
    gy_abs = (gy_pos >= gy_neg) ? gy_pos - gy_neg : gy_neg - gy_pos;
    mag    = {2'b0, gx_abs} + {2'b0, gy_abs};
    sat    = (mag > 12'd255) ? 8'hFF : mag[7:0];
    pix    = sat;
    if (BINARY != 0) pix = (sat >= THRESH) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix2_q    <= '0;
      v2_q      <= 1'b0;
      rgb2_q    <= '0;
      pass2_q   <= '0;
      out_R     <= '0;
      out_G     <= '0;
      out_B     <= '0;
      pass_thru <= '0;
    end else begin
      pix2_q    <= border1_q ? pix : 8'h00;
      v2_q      <= v1_q;
      rgb2_q    <= rgb1_q;
      pass2_q   <= pass1_q;
      pass_thru <= pass2_q;
      if (en_frame_q && v2_q) begin
        out_R <= pix2_q;
        out_G <= pix2_q;
        out_B <= pix2_q;
      end else begin
        out_R <= rgb2_q[23:16];
        out_G <= rgb2_q[15:8];
        out_B <= rgb2_q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge on 8-pixel lines: a magnitude instance and a binary
// instance share all inputs; each frame result is captured and checked against hand values.
module tb_sobel_edge;
  localparam int H    = 8;
  localparam int NPIX = 32;

  logic        clk = 1'b0;
  logic        rst, enable, frame_en, in_valid;
  logic [7:0]  in_r, in_g, in_b;
  logic [23:0] pass_in;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic [23:0] a_pass, b_pass;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img [NPIX];
  logic [7:0]  exp_a [NPIX];
  logic [7:0]  exp_b [NPIX];
  logic [7:0]  got_r [NPIX], got_g [NPIX], got_b [NPIX];
  logic [7:0]  got_br [NPIX], got_bg [NPIX], got_bb [NPIX];
  logic [23:0] got_pass [NPIX];

  sobel_edge #(.H_ACTIVE(H), .BINARY(0), .THRESH(8'd64)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .frame_en(frame_en), .in_valid(in_valid),
    .in_R(in_r), .in_G(in_g), .in_B(in_b), .out_R(a_r), .out_G(a_g), .out_B(a_b),
    .pass_in(pass_in), .pass_thru(a_pass));

  sobel_edge #(.H_ACTIVE(H), .BINARY(1), .THRESH(8'd64)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .frame_en(frame_en), .in_valid(in_valid),
    .in_R(in_r), .in_G(in_g), .in_B(in_b), .out_R(b_r), .out_G(b_g), .out_B(b_b),
    .pass_in(pass_in), .pass_thru(b_pass));

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic drive_cycle(input logic v, input logic fe, input logic [7:0] r,
                             input logic [7:0] g, input logic [7:0] b, input logic [23:0] p);
    in_valid = v; frame_en = fe; in_r = r; in_g = g; in_b = b; pass_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int idx);
    got_r[idx] = a_r;  got_g[idx] = a_g;  got_b[idx] = a_b;
    got_br[idx] = b_r; got_bg[idx] = b_g; got_bb[idx] = b_b;
    got_pass[idx] = a_pass;
  endtask

  // One 8x4 frame from img[]; output for pixel i appears after the edge of pixel i+2.
  task automatic stream_frame(input logic en_start, input int toggle_at,
                              input logic en_toggle, input logic collide);
    enable = en_start;
    if (!collide) drive_cycle(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 24'h0);
    for (int i = 0; i < NPIX; i++) begin
      if (i == toggle_at) enable = en_toggle;
      drive_cycle(1'b1, collide && (i == 0), 8'h11, img[i], 8'h22, 24'h5A0000 | 24'(i));
      if (i >= 2) capture(i - 2);
    end
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
    capture(NPIX - 2);
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
    capture(NPIX - 1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, i == 0, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                  8'($urandom_range(1, 255)), 24'($urandom_range(1, 24'hFFFFFF)));
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_cycle(1'b1, 1'b1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
                  8'($urandom_range(1, 255)), 24'($urandom_range(1, 24'hFFFFFF)));
      checks++;
      if ({a_r, a_g, a_b} !== 24'h0 || {b_r, b_g, b_b} !== 24'h0) begin
        errors++;
        $display("FAIL reset_out edge%0d: got %h%h%h / %h%h%h want 0", k, a_r, a_g, a_b, b_r, b_g, b_b);
      end
      checks++;
      if (a_pass !== 24'h0 || b_pass !== 24'h0) begin
        errors++;
        $display("FAIL reset_pass edge%0d: got %h / %h want 0", k, a_pass, b_pass);
      end
      checks++;
      if (dut_a.en_frame_q !== 1'b0) begin
        errors++;
        $display("FAIL reset_en_frame edge%0d: got %b want 0", k, dut_a.en_frame_q);
      end
    end
    rst = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_bypass;
    logic [7:0]  hr [12], hg [12], hb [12];
    logic [23:0] hp [12];
    logic        hv [12];
    for (int n = 0; n < 12; n++) begin
      hr[n] = 8'h00; hg[n] = 8'h00; hb[n] = 8'h00; hp[n] = 24'h0; hv[n] = 1'b0;
    end
    hr[2] = 8'd12; hg[2] = 8'd34; hb[2] = 8'd56; hp[2] = 24'hABCDEF; hv[2] = 1'b1;
    for (int n = 3; n < 10; n++) begin
      hr[n] = 8'(n * 7); hg[n] = 8'(n * 13); hb[n] = 8'(n * 29);
      hp[n] = 24'h100000 + 24'(n); hv[n] = n[0];
    end
    enable = 1'b0;
    for (int n = 0; n < 12; n++) begin
      drive_cycle(hv[n], n == 0, hr[n], hg[n], hb[n], hp[n]);
      if (n >= 2) begin
        checks++;
        if (a_r !== hr[n-2] || a_g !== hg[n-2] || a_b !== hb[n-2] || a_pass !== hp[n-2]) begin
          errors++;
          $display("FAIL bypass cyc%0d: got %0d/%0d/%0d %h want %0d/%0d/%0d %h",
                   n, a_r, a_g, a_b, a_pass, hr[n-2], hg[n-2], hb[n-2], hp[n-2]);
        end
      end
    end
  endtask

  task automatic test_flat;
    for (int i = 0; i < NPIX; i++) begin
      img[i] = 8'd100;
      exp_a[i] = 8'd0;
      exp_b[i] = 8'd0;
    end
    stream_frame(1'b1, -1, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_r[i] !== exp_a[i] || got_g[i] !== exp_a[i] || got_b[i] !== exp_a[i] ||
          got_bg[i] !== exp_b[i] || got_pass[i] !== (24'h5A0000 | 24'(i))) begin
        errors++;
        $display("FAIL flat px%0d: got %0d/%0d/%0d bin %0d pass %h want %0d bin %0d",
                 i, got_r[i], got_g[i], got_b[i], got_bg[i], got_pass[i], exp_a[i], exp_b[i]);
      end
    end
  endtask

  // Step between cols 3 and 4: Gx = 4*200 for centres 3 and 4 once three lines exist.
  task automatic fill_vstep;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < H; c++) begin
        img[r*H+c]   = (c >= 4) ? 8'd200 : 8'd0;
        exp_a[r*H+c] = (r >= 2 && (c == 4 || c == 5)) ? 8'd255 : 8'd0;
        exp_b[r*H+c] = exp_a[r*H+c];
      end
  endtask

  task automatic test_vstep;
    fill_vstep();
    stream_frame(1'b1, -1, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_r[i] !== exp_a[i] || got_g[i] !== exp_a[i] || got_b[i] !== exp_a[i] ||
          got_br[i] !== exp_b[i] || got_bg[i] !== exp_b[i] || got_bb[i] !== exp_b[i] ||
          got_pass[i] !== (24'h5A0000 | 24'(i))) begin
        errors++;
        $display("FAIL vstep px%0d: got %0d/%0d/%0d bin %0d pass %h want %0d",
                 i, got_r[i], got_g[i], got_b[i], got_bg[i], got_pass[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_frame_gate;
    fill_vstep();
    stream_frame(1'b0, 10, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_r[i] !== 8'h11 || got_g[i] !== img[i] || got_b[i] !== 8'h22 || got_bg[i] !== img[i]) begin
        errors++;
        $display("FAIL gate_on px%0d: got %0d/%0d/%0d bin %0d want 17/%0d/34",
                 i, got_r[i], got_g[i], got_b[i], got_bg[i], img[i]);
      end
    end
    stream_frame(1'b1, 10, 1'b0, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_r[i] !== exp_a[i] || got_g[i] !== exp_a[i] || got_b[i] !== exp_a[i] ||
          got_bg[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL gate_off px%0d: got %0d/%0d/%0d bin %0d want %0d",
                 i, got_r[i], got_g[i], got_b[i], got_bg[i], exp_a[i]);
      end
    end
  endtask

  // Line 0 = 0, lines 1-3 = y: only row 2 sees the step, |Gy| = 4*y, Gx = 0.
  task automatic test_binary(input int y, input logic collide);
    int mag;
    mag = 4 * y;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < H; c++) begin
        img[r*H+c]   = (r == 0) ? 8'd0 : 8'(y);
        exp_a[r*H+c] = (r == 2 && c >= 2) ? ((mag > 255) ? 8'd255 : 8'(mag)) : 8'd0;
        exp_b[r*H+c] = (r == 2 && c >= 2 && mag >= 64) ? 8'd255 : 8'd0;
      end
    if (collide)
      for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b0, 8'h33, 8'd77, 8'h44, 24'h0);
    stream_frame(1'b1, -1, 1'b1, collide);
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if (got_br[i] !== exp_b[i] || got_bg[i] !== exp_b[i] || got_bb[i] !== exp_b[i] ||
          got_g[i] !== exp_a[i] || got_pass[i] !== (24'h5A0000 | 24'(i))) begin
        errors++;
        $display("FAIL binary y%0d col%0b px%0d: bin %0d/%0d/%0d mag %0d pass %h want bin %0d mag %0d",
                 y, collide, i, got_br[i], got_bg[i], got_bb[i], got_g[i], got_pass[i], exp_b[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    enable = 1'b1;
    drive_cycle(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 24'h0);
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b0, 8'd99, 8'd200, 8'd99, 24'h777777);
    rst = 1'b1;
    drive_cycle(1'b1, 1'b0, 8'd99, 8'd200, 8'd99, 24'h777777);
    checks++;
    if ({a_r, a_g, a_b} !== 24'h0 || a_pass !== 24'h0) begin
      errors++;
      $display("FAIL midrst_out: got %0d/%0d/%0d %h want 0", a_r, a_g, a_b, a_pass);
    end
    rst = 1'b0;
    drive_cycle(1'b1, 1'b0, 8'd5, 8'd200, 8'd6, 24'h000123);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({a_r, a_g, a_b} !== 24'h0 || a_pass !== 24'h0) begin
        errors++;
        $display("FAIL midrst_flush%0d: got %0d/%0d/%0d %h want 0", k, a_r, a_g, a_b, a_pass);
      end
      drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 24'h0);
    end
    checks++;
    if (a_r !== 8'd5 || a_g !== 8'd200 || a_b !== 8'd6 || a_pass !== 24'h000123) begin
      errors++;
      $display("FAIL midrst_bypass: got %0d/%0d/%0d %h want 5/200/6 000123", a_r, a_g, a_b, a_pass);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; frame_en = 1'b0; in_valid = 1'b0;
    in_r = 8'h00; in_g = 8'h00; in_b = 8'h00; pass_in = 24'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    test_reset();
    test_bypass();
    test_flat();
    test_vstep();
    test_frame_gate();
    test_binary(20, 1'b0);
    test_binary(10, 1'b0);
    test_binary(16, 1'b0);
    test_binary(20, 1'b1);
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
